// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU background fetch sequencer: state encoding
// and the fixed address-map constants of the PPU bus.
package ppu_pkg;

   // State encoding kept as plain constants so legacy tools can consume it.
   typedef logic [3:0] fetch_state_t;

   localparam fetch_state_t ST_IDLE  = 4'd0;
   localparam fetch_state_t ST_NT_A  = 4'd1;
   localparam fetch_state_t ST_NT_D  = 4'd2;
   localparam fetch_state_t ST_AT_A  = 4'd3;
   localparam fetch_state_t ST_AT_D  = 4'd4;
   localparam fetch_state_t ST_PLO_A = 4'd5;
   localparam fetch_state_t ST_PLO_D = 4'd6;
   localparam fetch_state_t ST_PHI_A = 4'd7;
   localparam fetch_state_t ST_PHI_D = 4'd8;
   localparam fetch_state_t ST_FIN   = 4'd9;

   localparam logic [13:0] NT_BASE      = 14'h2000;
   localparam logic [13:0] AT_OFFSET    = 14'h03C0;
   localparam logic [13:0] PT_HI_OFFSET = 14'h0008;

   // True for the address-presentation half of each fetch.
   function automatic logic is_addr_state(input fetch_state_t s);
      logic r;
      case (s)
         ST_NT_A, ST_AT_A, ST_PLO_A, ST_PHI_A: r = 1'b1;
         default:                              r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ppu_fetch_addr.sv
// Combinational address former: maps a fetch state plus the current tile
// coordinates onto the 14-bit PPU bus address, and gives the bit offset of
// this tile's 2-bit palette field inside the attribute byte.
module ppu_fetch_addr
   import ppu_pkg::*;
(
   input  logic [3:0]  state_i,
   input  logic [1:0]  nt_i,
   input  logic [4:0]  cx_i,
   input  logic [4:0]  cy_i,
   input  logic [2:0]  fine_y_i,
   input  logic [7:0]  tile_id_i,
   input  logic        bg_pt_sel_i,
   output logic [13:0] addr_o,
   output logic [2:0]  attr_shift_o
);

   logic [13:0] nt_addr_s;
   logic [13:0] at_addr_s;
   logic [13:0] plo_addr_s;
   logic [13:0] phi_addr_s;

   // Build every candidate address, then pick by fetch kind.
   always_comb begin
      nt_addr_s  = NT_BASE | {2'b00, nt_i, cy_i, cx_i};
      at_addr_s  = NT_BASE | AT_OFFSET | {2'b00, nt_i, 4'b0000, cy_i[4:2], cx_i[4:2]};
      plo_addr_s = {1'b0, bg_pt_sel_i, tile_id_i, 1'b0, fine_y_i};
      phi_addr_s = plo_addr_s + PT_HI_OFFSET;
      case (state_i)
         ST_NT_A,  ST_NT_D:  addr_o = nt_addr_s;
         ST_AT_A,  ST_AT_D:  addr_o = at_addr_s;
         ST_PLO_A, ST_PLO_D: addr_o = plo_addr_s;
         ST_PHI_A, ST_PHI_D: addr_o = phi_addr_s;
         default:            addr_o = 14'h0000;
      endcase
      // Quadrant within the 32x32-pixel attribute block picks the field.
      attr_shift_o = {cy_i[1], cx_i[1], 1'b0};
   end

endmodule

// File: rtl/ppu_bg_fetch.sv
// Background tile fetch sequencer. Each tile costs eight cycles: four
// two-cycle fetches (nametable, attribute, pattern low, pattern high) against
// one-cycle-latency memory, followed by a one-cycle tile strobe that overlaps
// the next tile's first fetch.
module ppu_bg_fetch
   import ppu_pkg::*;
#(
   parameter int TILE_COUNT = 34
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        line_start,
   input  logic [4:0]  coarse_x,
   input  logic [4:0]  coarse_y,
   input  logic [2:0]  fine_y,
   input  logic [1:0]  nt_sel,
   input  logic        bg_pt_sel,
   output logic [13:0] chr_a_out,
   output logic        chr_r_nw_out,
   input  logic [7:0]  chr_d_in,
   output logic        tile_valid,
   output logic [7:0]  tile_pat_lo,
   output logic [7:0]  tile_pat_hi,
   output logic [1:0]  tile_attr,
   output logic        busy,
   output logic        done
);

   localparam logic [5:0] LAST_TILE = 6'(TILE_COUNT - 1);

   fetch_state_t state_q, state_d;
   logic [1:0]  nt_q, nt_d;
   logic [4:0]  cx_q, cx_d;
   logic [4:0]  cy_q, cy_d;
   logic [2:0]  fy_q, fy_d;
   logic        pt_q, pt_d;
   logic [5:0]  tile_cnt_q, tile_cnt_d;
   logic [7:0]  tile_id_q, tile_id_d;
   logic [7:0]  lo_stage_q, lo_stage_d;
   logic [1:0]  attr_stage_q, attr_stage_d;
   logic [13:0] chr_a_q, chr_a_d;
   logic        tile_valid_q, tile_valid_d;
   logic [7:0]  pat_lo_q, pat_lo_d;
   logic [7:0]  pat_hi_q, pat_hi_d;
   logic [1:0]  attr_q, attr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [13:0] addr_s;
   logic [2:0]  attr_shift_s;
   logic [7:0]  at_shifted_s;

   // The address is formed from next-state values so it lands on the bus
   // in the first cycle of each fetch.
   ppu_fetch_addr u_addr (
      .state_i      (state_d),
      .nt_i         (nt_d),
      .cx_i         (cx_d),
      .cy_i         (cy_d),
      .fine_y_i     (fy_d),
      .tile_id_i    (tile_id_d),
      .bg_pt_sel_i  (pt_d),
      .addr_o       (addr_s),
      .attr_shift_o (attr_shift_s)
   );

   // Sequencing, coordinate stepping and capture of fetched bytes.
   always_comb begin
      state_d      = state_q;
      nt_d         = nt_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      fy_d         = fy_q;
      pt_d         = pt_q;
      tile_cnt_d   = tile_cnt_q;
      tile_id_d    = tile_id_q;
      lo_stage_d   = lo_stage_q;
      tile_valid_d = 1'b0;
      pat_lo_d     = pat_lo_q;
      pat_hi_d     = pat_hi_q;
      attr_d       = attr_q;
      case (state_q)
         ST_IDLE: begin
            if (line_start) begin
               state_d    = ST_NT_A;
               nt_d       = nt_sel;
               cx_d       = coarse_x;
               cy_d       = coarse_y;
               fy_d       = fine_y;
               pt_d       = bg_pt_sel;
               tile_cnt_d = 6'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_NT_A:  state_d = ST_NT_D;
         ST_NT_D: begin
            state_d   = ST_AT_A;
            tile_id_d = chr_d_in;
         end
         ST_AT_A:  state_d = ST_AT_D;
         ST_AT_D:  state_d = ST_PLO_A;
         ST_PLO_A: state_d = ST_PLO_D;
         ST_PLO_D: begin
            state_d    = ST_PHI_A;
            lo_stage_d = chr_d_in;
         end
         ST_PHI_A: state_d = ST_PHI_D;
         ST_PHI_D: begin
            tile_valid_d = 1'b1;
            pat_lo_d     = lo_stage_q;
            pat_hi_d     = chr_d_in;
            attr_d       = attr_stage_q;
            if (tile_cnt_q == LAST_TILE) begin
               state_d = ST_FIN;
            end else begin
               state_d    = ST_NT_A;
               tile_cnt_d = tile_cnt_q + 6'd1;
               cx_d       = cx_q + 5'd1;
               // Crossing column 31 moves into the horizontally adjacent table.
               if (cx_q == 5'd31) begin
                  nt_d = {nt_q[1], ~nt_q[0]};
               end else begin
                  nt_d = nt_q;
               end
            end
         end
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Palette extraction, bus address hold and status strobes.
   always_comb begin
      at_shifted_s = chr_d_in >> attr_shift_s;
      if (state_q == ST_AT_D) begin
         attr_stage_d = at_shifted_s[1:0];
      end else begin
         attr_stage_d = attr_stage_q;
      end
      if (is_addr_state(state_d)) begin
         chr_a_d = addr_s;
      end else begin
         chr_a_d = chr_a_q;
      end
      busy_d = (state_d != ST_IDLE) && (state_d != ST_FIN);
      done_d = (state_d == ST_FIN);
   end

   // State and output registers.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         nt_q         <= 2'd0;
         cx_q         <= 5'd0;
         cy_q         <= 5'd0;
         fy_q         <= 3'd0;
         pt_q         <= 1'b0;
         tile_cnt_q   <= 6'd0;
         tile_id_q    <= 8'h00;
         lo_stage_q   <= 8'h00;
         attr_stage_q <= 2'd0;
         chr_a_q      <= 14'h0000;
         tile_valid_q <= 1'b0;
         pat_lo_q     <= 8'h00;
         pat_hi_q     <= 8'h00;
         attr_q       <= 2'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         nt_q         <= nt_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         fy_q         <= fy_d;
         pt_q         <= pt_d;
         tile_cnt_q   <= tile_cnt_d;
         tile_id_q    <= tile_id_d;
         lo_stage_q   <= lo_stage_d;
         attr_stage_q <= attr_stage_d;
         chr_a_q      <= chr_a_d;
         tile_valid_q <= tile_valid_d;
         pat_lo_q     <= pat_lo_d;
         pat_hi_q     <= pat_hi_d;
         attr_q       <= attr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign chr_a_out    = chr_a_q;
   assign chr_r_nw_out = 1'b1;
   assign tile_valid   = tile_valid_q;
   assign tile_pat_lo  = pat_lo_q;
   assign tile_pat_hi  = pat_hi_q;
   assign tile_attr    = attr_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
